// File: rtl/csr_spmv_sequencer.sv
// CSR sparse-matrix read sequencer: walks row pointers, fetches value/column pairs
// and streams one (value, col, row) beat per nonzero (or one beat per empty row).
module csr_spmv_sequencer #(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 32,
    parameter int ROW_W   = 10,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ROW_W-1:0]  num_rows,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] row_addr,
    input  logic [DATA_W-1:0] row_rdata,
    output logic [ADDR_W-1:0] nz_addr,
    input  logic [DATA_W-1:0] val_rdata,
    input  logic [DATA_W-1:0] col_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_value,
    output logic [DATA_W-1:0] out_col,
    output logic [ROW_W-1:0]  out_row,
    output logic              out_last,
    output logic              out_empty
);

    localparam int CNT_W = $clog2(RAM_LAT + 1);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(RAM_LAT);

    typedef enum logic [3:0] {
        IDLE, PTR0, PTRN, EMPTY, NZ_ISSUE, NZ_WAIT, NZ_OUT, NEXT, FIN
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ROW_W-1:0]  num_r;
    logic [ROW_W-1:0]  r;
    logic [ADDR_W-1:0] lo;
    logic [ADDR_W-1:0] hi;
    logic [ADDR_W-1:0] k;
    logic [ADDR_W-1:0] row_data;
    logic              rd_ready;
    logic              last_row;
    logic              unused_row_bits;

    assign nz_addr         = k;
    assign row_data        = row_rdata[ADDR_W-1:0];
    assign rd_ready        = (cnt == LAT);
    assign last_row        = ((r + ROW_W'(1)) == num_r);
    assign unused_row_bits = ^(row_rdata >> ADDR_W);

    // cnt counts cycles since the last address change; data is usable once it reaches RAM_LAT.
    // The next row pointer address is issued on entry to NEXT so PTRN costs only RAM_LAT cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            num_r     <= '0;
            r         <= '0;
            lo        <= '0;
            hi        <= '0;
            k         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            row_addr  <= '0;
            out_valid <= 1'b0;
            out_value <= '0;
            out_col   <= '0;
            out_row   <= '0;
            out_last  <= 1'b0;
            out_empty <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cnt != LAT) cnt <= cnt + CNT_W'(1);
            case (state)
                IDLE: begin
                    if (start) begin
                        num_r    <= num_rows;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        r        <= '0;
                        row_addr <= '0;
                        cnt      <= '0;
                        state    <= (num_rows == '0) ? FIN : PTR0;
                    end
                end
                PTR0: begin
                    if (rd_ready) begin
                        lo       <= row_data;
                        row_addr <= ADDR_W'(1);
                        cnt      <= '0;
                        state    <= PTRN;
                    end
                end
                PTRN: begin
                    if (rd_ready) begin
                        hi <= row_data;
                        if (row_data > lo) begin
                            k     <= lo;
                            cnt   <= '0;
                            state <= NZ_ISSUE;
                        end else begin
                            // A decreasing pointer is flagged and the row is emitted as empty.
                            if (row_data < lo) err <= 1'b1;
                            out_valid <= 1'b1;
                            out_empty <= 1'b1;
                            out_last  <= 1'b1;
                            out_row   <= r;
                            out_value <= '0;
                            out_col   <= '0;
                            state     <= EMPTY;
                        end
                    end
                end
                EMPTY: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= NEXT;
                        if (!last_row) begin
                            row_addr <= ADDR_W'(r) + ADDR_W'(2);
                            cnt      <= '0;
                        end
                    end
                end
                NZ_ISSUE: state <= NZ_WAIT;
                NZ_WAIT: begin
                    if (rd_ready) begin
                        out_value <= val_rdata;
                        out_col   <= col_rdata;
                        out_row   <= r;
                        out_last  <= (k == hi - ADDR_W'(1));
                        out_empty <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= NZ_OUT;
                    end
                end
                NZ_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            state <= NEXT;
                            if (!last_row) begin
                                row_addr <= ADDR_W'(r) + ADDR_W'(2);
                                cnt      <= '0;
                            end
                        end else begin
                            k     <= k + ADDR_W'(1);
                            cnt   <= '0;
                            state <= NZ_ISSUE;
                        end
                    end
                end
                NEXT: begin
                    lo    <= hi;
                    r     <= r + ROW_W'(1);
                    state <= last_row ? FIN : PTRN;
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_spmv_sequencer.sv
// Bench for csr_spmv_sequencer: RAM models with configurable latency and a row-by-row
// CSR reference model that predicts every beat, the error flag and the done pulse.
module tb_csr_spmv_sequencer;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int ROW_W  = 10;
    localparam int LAT    = 2;

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [DATA_W-1:0] val;
        logic [DATA_W-1:0] col;
        logic              last;
        logic              empty;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ROW_W-1:0]  num_rows;
    logic              busy, done, err;
    logic [ADDR_W-1:0] row_addr, nz_addr;
    logic [DATA_W-1:0] row_rdata, val_rdata, col_rdata;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_value, out_col;
    logic [ROW_W-1:0]  out_row;
    logic              out_last, out_empty;

    logic [DATA_W-1:0] rowptr  [0:63];
    logic [DATA_W-1:0] val_mem [0:255];
    logic [DATA_W-1:0] col_mem [0:255];
    logic [DATA_W-1:0] row_pipe [LAT];
    logic [DATA_W-1:0] val_pipe [LAT];
    logic [DATA_W-1:0] col_pipe [LAT];

    beat_t exp_q[$];
    bit    exp_err;
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    csr_spmv_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROW_W(ROW_W), .RAM_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
        .busy(busy), .done(done), .err(err),
        .row_addr(row_addr), .row_rdata(row_rdata),
        .nz_addr(nz_addr), .val_rdata(val_rdata), .col_rdata(col_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_value(out_value), .out_col(out_col), .out_row(out_row),
        .out_last(out_last), .out_empty(out_empty)
    );

    always @(posedge clk) begin
        row_pipe[0] <= rowptr[row_addr[5:0]];
        val_pipe[0] <= val_mem[nz_addr[7:0]];
        col_pipe[0] <= col_mem[nz_addr[7:0]];
        for (int i = 1; i < LAT; i++) begin
            row_pipe[i] <= row_pipe[i-1];
            val_pipe[i] <= val_pipe[i-1];
            col_pipe[i] <= col_pipe[i-1];
        end
    end
    assign row_rdata = row_pipe[LAT-1];
    assign val_rdata = val_pipe[LAT-1];
    assign col_rdata = col_pipe[LAT-1];

    task automatic build_expected(input int n);
        beat_t b;
        int lo, hi;
        exp_q.delete();
        exp_err = 1'b0;
        for (int r = 0; r < n; r++) begin
            lo = int'(rowptr[r][ADDR_W-1:0]);
            hi = int'(rowptr[r+1][ADDR_W-1:0]);
            if (hi > lo) begin
                for (int j = lo; j < hi; j++) begin
                    b.row = ROW_W'(r); b.val = val_mem[j]; b.col = col_mem[j];
                    b.last = (j == hi - 1); b.empty = 1'b0;
                    exp_q.push_back(b);
                end
            end else begin
                if (hi < lo) exp_err = 1'b1;
                b.row = ROW_W'(r); b.val = '0; b.col = '0; b.last = 1'b1; b.empty = 1'b1;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic load_basic();
        rowptr[0] = 0; rowptr[1] = 2; rowptr[2] = 3; rowptr[3] = 5;
        val_mem[0] = 5; val_mem[1] = 6; val_mem[2] = 7; val_mem[3] = 8; val_mem[4] = 9;
        col_mem[0] = 0; col_mem[1] = 2; col_mem[2] = 1; col_mem[3] = 0; col_mem[4] = 2;
    endtask

    // mode: 0 ready always, 1 ready toggles, 2 random ready; poke: cycle to pulse start while busy.
    task automatic run_pass(input string name, input int n, input int mode, input int poke);
        beat_t cur, snap, e;
        int    cyc, dones, tail;
        bit    stalled;
        build_expected(n);
        num_rows = ROW_W'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL %s start: busy=%b err=%b required busy=1 err=0", name, busy, err);
        end
        cyc = 0; dones = 0; tail = -1; stalled = 1'b0; snap = '0;
        while (cyc < 3000 && tail != 0) begin
            cur = {out_row, out_value, out_col, out_last, out_empty};
            if (stalled) begin
                total++;
                if (out_valid !== 1'b1 || cur !== snap) begin
                    bad++;
                    $display("FAIL %s stall hold: valid=%b beat=%h required valid=1 beat=%h",
                             name, out_valid, cur, snap);
                end
                stalled = 1'b0;
            end
            if (done === 1'b1) begin
                dones++;
                if (tail < 0) tail = 3;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = (cyc == poke);
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL %s extra beat: got %h required none", name, cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            bad++;
                            $display("FAIL %s beat: got row=%0d val=%0h col=%0h last=%b empty=%b required row=%0d val=%0h col=%0h last=%b empty=%b",
                                     name, cur.row, cur.val, cur.col, cur.last, cur.empty,
                                     e.row, e.val, e.col, e.last, e.empty);
                        end
                    end
                end else begin
                    snap = cur;
                    stalled = 1'b1;
                end
            end
            if (tail > 0) tail--;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL %s done pulses: got %0d required 1", name, dones);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s missing beats: got %0d left required 0", name, exp_q.size());
        end
        total++;
        if (err !== exp_err) begin
            bad++;
            $display("FAIL %s err: got %b required %b", name, err, exp_err);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy after done: got %b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        total++;
        if ({out_valid, busy, done, err} !== 4'b0) begin
            bad++;
            $display("FAIL reset ctrl: got valid/busy/done/err=%b required 0000",
                     {out_valid, busy, done, err});
        end
        total++;
        if ({row_addr, nz_addr} !== '0) begin
            bad++;
            $display("FAIL reset addr: got row_addr=%0d nz_addr=%0d required 0", row_addr, nz_addr);
        end
        total++;
        if ({out_value, out_col, out_row, out_last, out_empty} !== '0) begin
            bad++;
            $display("FAIL reset data: got %h required 0",
                     {out_value, out_col, out_row, out_last, out_empty});
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({out_valid, busy, done} !== 3'b0) begin
            bad++;
            $display("FAIL idle after reset: got valid/busy/done=%b required 000",
                     {out_valid, busy, done});
        end
    endtask

    task automatic test_basic();
        load_basic();
        run_pass("basic", 3, 0, -1);
    endtask

    task automatic test_empty_row();
        rowptr[0] = 0; rowptr[1] = 0; rowptr[2] = 1;
        val_mem[0] = 32'hDEAD_0001; col_mem[0] = 7;
        run_pass("empty_row", 2, 0, -1);
    endtask

    task automatic test_stall();
        load_basic();
        run_pass("stall_toggle", 3, 1, -1);
    endtask

    task automatic test_zero_rows();
        num_rows = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL zero_rows cycle1: done=%b busy=%b required done=0 busy=1", done, busy);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL zero_rows cycle2: done=%b busy=%b valid=%b required 1 0 0",
                     done, busy, out_valid);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL zero_rows pulse width: done=%b required 0", done);
        end
    endtask

    task automatic test_start_while_busy();
        load_basic();
        run_pass("start_busy", 3, 0, 4);
    endtask

    task automatic test_err();
        rowptr[0] = 3; rowptr[1] = 1;
        run_pass("decreasing_ptr", 1, 0, -1);
        load_basic();
        run_pass("err_cleared", 3, 0, -1);
    endtask

    task automatic test_reset_mid_pass();
        bit found = 1'b0;
        load_basic();
        num_rows = ROW_W'(3);
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1 && out_row === ROW_W'(1)) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL mid_reset timeout: row 1 beat not seen required within 500 cycles");
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({out_valid, busy, done} !== 3'b0) begin
            bad++;
            $display("FAIL mid_reset ctrl: valid/busy/done=%b required 000", {out_valid, busy, done});
        end
        total++;
        if ({out_row, out_value, row_addr, nz_addr} !== '0) begin
            bad++;
            $display("FAIL mid_reset data: got %h required 0", {out_row, out_value, row_addr, nz_addr});
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        run_pass("replay", 3, 0, -1);
    endtask

    task automatic test_random();
        int n, p;
        for (int it = 0; it < 10; it++) begin
            n = $urandom_range(1, 8);
            p = $urandom_range(1, 5);
            for (int i = 0; i <= n; i++) begin
                if (i > 0) begin
                    if (it % 4 == 3 && i == 1) p = p - 1;
                    else p = p + $urandom_range(0, 3);
                end
                rowptr[i] = {18'($urandom), 14'(p)};
            end
            for (int j = 0; j < 64; j++) begin
                val_mem[j] = $urandom;
                col_mem[j] = $urandom;
            end
            run_pass($sformatf("random%0d", it), n, 2, -1);
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        num_rows = '0;
        for (int i = 0; i < 64; i++) rowptr[i] = '0;
        for (int i = 0; i < 256; i++) begin
            val_mem[i] = '0;
            col_mem[i] = '0;
        end
        test_reset();
        test_basic();
        test_empty_row();
        test_stall();
        test_zero_rows();
        test_start_while_busy();
        test_err();
        test_reset_mid_pass();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
